// File: rtl/swd_xfer_seq.sv
// swd_xfer_seq: DAP transfer sequencer in front of the SWD bit engine.
// Optional value-match reads are built when SWDSEQ_MATCH_EN is defined.
module swd_xfer_seq #(
  parameter int RETRY_W = 16,
  parameter int TO_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_apndp,
  input  logic               cmd_rnw,
  input  logic [1:0]         cmd_addr32,
  input  logic [31:0]        cmd_wdata,
  input  logic               cmd_match,
  input  logic [RETRY_W-1:0] wait_retry,
  input  logic [RETRY_W-1:0] match_retry,
  input  logic [31:0]        match_mask,
  input  logic [31:0]        match_val,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_ack,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_mismatch,
  output logic               swd_go,
  input  logic               swd_done,
  output logic [1:0]         swd_addr32,
  output logic               swd_rnw,
  output logic               swd_apndp,
  output logic [31:0]        swd_din,
  input  logic [2:0]         swd_ack,
  input  logic [31:0]        swd_dout,
  input  logic               swd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_EVAL,
    S_RESP
  } state_t;

  localparam logic [2:0] ACK_OK   = 3'b100;
  localparam logic [2:0] ACK_WAIT = 3'b010;

  localparam logic [TO_W-1:0] TO_LAST =
    {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);
  localparam logic [RETRY_W-1:0] RT_ONE = RETRY_W'(1);

  state_t state, state_n;

  logic               c_apndp;
  logic               c_rnw;
  logic [1:0]         c_addr;
  logic [31:0]        c_wdata;
  logic [RETRY_W-1:0] wait_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [2:0]         x_ack;
  logic [31:0]        x_dout;
  logic               x_err;

  logic accept;
  logic to_hit;
  logic tmo;
  logic is_ok;
  logic retry_wait;
  logic retry_match;
  logic m_fail;
  logic rsp_load;

  // Engine request fields only move when a new command is accepted.
  assign swd_addr32 = c_addr;
  assign swd_rnw    = c_rnw;
  assign swd_apndp  = c_apndp;
  assign swd_din    = c_wdata;

  assign cmd_ready  = rst_n & (state == S_IDLE) & swd_done;
  assign swd_go     = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESP);
  assign accept     = cmd_valid & cmd_ready;
  assign to_hit     = (to_cnt == TO_LAST);
  assign is_ok      = (x_ack == ACK_OK);
  assign retry_wait = (x_ack == ACK_WAIT) &&
                      (wait_cnt < wait_retry);
  assign rsp_load   = (state != S_RESP) &&
                      (state_n == S_RESP);

`ifdef SWDSEQ_MATCH_EN
  logic               c_match;
  logic [RETRY_W-1:0] match_cnt;
  logic               m_active;
  logic               m_miss;

  assign m_active = c_match & c_rnw & is_ok & ~x_err;
  assign m_miss   = ((x_dout ^ match_val) & match_mask) != 32'd0;
  assign retry_match = m_active & m_miss &
                       (match_cnt < match_retry);
  assign m_fail   = m_active & m_miss;

  // Match command flag and re-read counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_match   <= 1'b0;
      match_cnt <= '0;
    end else if (accept) begin
      c_match   <= cmd_match;
      match_cnt <= '0;
    end else if (state == S_EVAL && !retry_wait &&
                 retry_match) begin
      match_cnt <= match_cnt + RT_ONE;
    end
  end
`else
  logic unused_match;
  assign unused_match = ^{cmd_match, match_retry,
                          match_mask, match_val};
  assign retry_match  = 1'b0;
  assign m_fail       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state; timeouts bail straight to a response.
  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (!swd_done) begin
          state_n = S_RUN;
        end else if (to_hit) begin
          state_n = S_RESP;
          tmo     = 1'b1;
        end
      end
      S_RUN: begin
        if (swd_done) begin
          state_n = S_EVAL;
        end else if (to_hit) begin
          state_n = S_RESP;
          tmo     = 1'b1;
        end
      end
      S_EVAL: begin
        if (retry_wait || retry_match) state_n = S_ISSUE;
        else                           state_n = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Timeout counter restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_n != state) begin
      to_cnt <= '0;
    end else if (state == S_ISSUE || state == S_RUN) begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

  // Command latch, WAIT retry count and engine result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_apndp  <= 1'b0;
      c_rnw    <= 1'b0;
      c_addr   <= 2'd0;
      c_wdata  <= 32'd0;
      wait_cnt <= '0;
      x_ack    <= 3'd0;
      x_dout   <= 32'd0;
      x_err    <= 1'b0;
    end else begin
      if (accept) begin
        c_apndp  <= cmd_apndp;
        c_rnw    <= cmd_rnw;
        c_addr   <= cmd_addr32;
        c_wdata  <= cmd_wdata;
        wait_cnt <= '0;
      end
      if (state == S_RUN && swd_done) begin
        x_ack  <= swd_ack;
        x_dout <= swd_dout;
        x_err  <= swd_err;
      end
      if (state == S_EVAL) begin
        if (retry_wait)       wait_cnt <= wait_cnt + RT_ONE;
        else if (retry_match) wait_cnt <= '0;
      end
    end
  end

  // Response registers, loaded once on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ack      <= 3'd0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else if (rsp_load) begin
      if (tmo) begin
        rsp_ack      <= 3'd0;
        rsp_rdata    <= 32'd0;
        rsp_err      <= 1'b1;
        rsp_mismatch <= 1'b0;
      end else begin
        rsp_ack      <= x_ack;
        rsp_rdata    <= (c_rnw && is_ok) ? x_dout : 32'd0;
        rsp_err      <= c_rnw & is_ok & x_err;
        rsp_mismatch <= m_fail;
      end
    end
  end

endmodule
